// File: rtl/terminal_char_arbiter.sv
// Character-write arbiter for the UART terminal: RX chars, local keys and the blinking cursor
// share the text driver port; local keys are queued for UART TX. Optional: LOCAL_ECHO_EN.
module terminal_char_arbiter #(
    parameter int BLINK_DIV = 25000000,
    parameter int WR_GAP    = 2,
    parameter int KEY_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       KEY_VALID,
    input  logic [7:0] KEY_CHAR,
    input  logic [7:0] SWITCHES,
    input  logic       RX_VALID,
    input  logic [7:0] RX_CHAR,
    input  logic       TX_READY,
    output logic       TX_WE,
    output logic [7:0] TX_DATA,
    output logic       CHAR_WE,
    output logic [7:0] CHAR,
    output logic       CURSOR_ON,
    output logic       BUSY,
    output logic       RX_DROP,
    output logic       KEY_DROP,
    output logic [2:0] DBG_STATE
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int GW = $clog2(WR_GAP + 1);
    localparam int AW = $clog2(KEY_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ERASE     = 3'd1,
        S_ERASE_GAP = 3'd2,
        S_WRITE     = 3'd3,
        S_WRITE_GAP = 3'd4
    } state_t;

    // What the pending WRITE strobe is for, so the right source is consumed.
    typedef enum logic [1:0] {
        K_RX  = 2'd0,
        K_KEY = 2'd1,
        K_ON  = 2'd2,
        K_OFF = 2'd3
    } kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    wr_char_q, wr_char_d;
    logic [7:0]    char_q, char_d;
    logic          cursor_q, cursor_d;

    logic [CW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          pend_q, pend_d;
    logic          wrap;
    logic          pend_clr;

    logic          rx_full_q, rx_full_d;
    logic [7:0]    rx_char_q, rx_char_d;
    logic          rx_drop_q, rx_drop_d;
    logic          rx_consume;

    logic [7:0]    mem [KEY_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] tx_ptr_q, tx_ptr_d;
    logic [PW-1:0] tx_used;
    logic          tx_avail;
    logic          key_full;
    logic          key_push;
    logic          key_drop_q, key_drop_d;

    logic          tx_we_q, tx_we_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_fire;

    logic          commit;
    logic [7:0]    commit_char;

`ifdef LOCAL_ECHO_EN
    logic [PW-1:0] disp_ptr_q, disp_ptr_d;
    logic [PW-1:0] disp_used;
    logic          disp_avail;
    logic          disp_adv;
`endif

    // Blink timebase
    always_comb begin
        wrap        = (blink_cnt_q == CW'(BLINK_DIV - 1));
        blink_cnt_d = wrap ? '0 : blink_cnt_q + CW'(1);
        phase_d     = phase_q ^ wrap;
        pend_d      = wrap | (pend_q & ~pend_clr);
    end

    // RX holding register: one entry, capture only when empty.
    always_comb begin
        rx_full_d = rx_full_q;
        rx_char_d = rx_char_q;
        rx_drop_d = RX_VALID & rx_full_q;
        if (RX_VALID && !rx_full_q) begin
            rx_full_d = 1'b1;
            rx_char_d = RX_CHAR;
        end else if (rx_consume) begin
            rx_full_d = 1'b0;
        end
    end

    // Key FIFO occupancy is set by whichever read pointer lags further behind.
    always_comb begin
        tx_used  = wr_ptr_q - tx_ptr_q;
        tx_avail = (tx_used != '0);
        key_full = (tx_used == PW'(KEY_DEPTH));
`ifdef LOCAL_ECHO_EN
        disp_used  = wr_ptr_q - disp_ptr_q;
        disp_avail = (disp_used != '0);
        key_full   = key_full | (disp_used == PW'(KEY_DEPTH));
`endif
        key_push   = KEY_VALID & ~key_full;
        key_drop_d = KEY_VALID & key_full;
        wr_ptr_d   = key_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    end

    // TX handshake: a load is issued only while TX_READY is high and never in two
    // consecutive cycles, giving the transmitter one cycle to drop TX_READY after a load.
    always_comb begin
        tx_fire   = TX_READY & tx_avail & ~tx_we_q;
        tx_we_d   = tx_fire;
        tx_data_d = tx_fire ? mem[tx_ptr_q[AW-1:0]] : tx_data_q;
        tx_ptr_d  = tx_fire ? tx_ptr_q + PW'(1) : tx_ptr_q;
    end

    // Write FSM next-state and strobe sequencing
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        gap_d       = gap_q;
        wr_char_d   = wr_char_q;
        char_d      = char_q;
        cursor_d    = cursor_q;
        pend_clr    = 1'b0;
        rx_consume  = 1'b0;
        commit      = 1'b0;
        commit_char = 8'h00;
`ifdef LOCAL_ECHO_EN
        disp_adv    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_full_q) begin
                    commit      = 1'b1;
                    commit_char = rx_char_q;
                    kind_d      = K_RX;
`ifdef LOCAL_ECHO_EN
                end else if (disp_avail) begin
                    commit      = 1'b1;
                    commit_char = mem[disp_ptr_q[AW-1:0]];
                    kind_d      = K_KEY;
`endif
                end else if (pend_q) begin
                    pend_clr = 1'b1;
                    if (phase_q && !cursor_q) begin
                        kind_d  = K_ON;
                        char_d  = SWITCHES;
                        state_d = S_WRITE;
                    end else if (!phase_q && cursor_q) begin
                        kind_d  = K_OFF;
                        char_d  = 8'h08;
                        state_d = S_WRITE;
                    end
                end
                if (commit) begin
                    wr_char_d = commit_char;
                    if (cursor_q) begin
                        char_d  = 8'h08;
                        state_d = S_ERASE;
                    end else begin
                        char_d  = commit_char;
                        state_d = S_WRITE;
                    end
                end
            end
            S_ERASE: begin
                cursor_d = 1'b0;
                gap_d    = GW'(WR_GAP - 1);
                state_d  = S_ERASE_GAP;
            end
            S_ERASE_GAP: begin
                if (gap_q == '0) begin
                    char_d  = wr_char_q;
                    state_d = S_WRITE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            S_WRITE: begin
                gap_d   = GW'(WR_GAP - 1);
                state_d = S_WRITE_GAP;
                case (kind_q)
                    K_RX:  rx_consume = 1'b1;
`ifdef LOCAL_ECHO_EN
                    K_KEY: disp_adv   = 1'b1;
`endif
                    K_ON:  cursor_d   = 1'b1;
                    K_OFF: cursor_d   = 1'b0;
                    default: ;
                endcase
            end
            S_WRITE_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef LOCAL_ECHO_EN
    assign disp_ptr_d = disp_adv ? disp_ptr_q + PW'(1) : disp_ptr_q;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            kind_q      <= K_RX;
            gap_q       <= '0;
            wr_char_q   <= '0;
            char_q      <= '0;
            cursor_q    <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            pend_q      <= 1'b0;
            rx_full_q   <= 1'b0;
            rx_char_q   <= '0;
            rx_drop_q   <= 1'b0;
            wr_ptr_q    <= '0;
            tx_ptr_q    <= '0;
            key_drop_q  <= 1'b0;
            tx_we_q     <= 1'b0;
            tx_data_q   <= '0;
`ifdef LOCAL_ECHO_EN
            disp_ptr_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            gap_q       <= gap_d;
            wr_char_q   <= wr_char_d;
            char_q      <= char_d;
            cursor_q    <= cursor_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            rx_full_q   <= rx_full_d;
            rx_char_q   <= rx_char_d;
            rx_drop_q   <= rx_drop_d;
            wr_ptr_q    <= wr_ptr_d;
            tx_ptr_q    <= tx_ptr_d;
            key_drop_q  <= key_drop_d;
            tx_we_q     <= tx_we_d;
            tx_data_q   <= tx_data_d;
`ifdef LOCAL_ECHO_EN
            disp_ptr_q  <= disp_ptr_d;
`endif
        end
    end

    // Storage only; emptiness is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (key_push) begin
            mem[wr_ptr_q[AW-1:0]] <= KEY_CHAR;
        end
    end

    assign CHAR_WE   = (state_q == S_ERASE) || (state_q == S_WRITE);
    assign CHAR      = char_q;
    assign CURSOR_ON = cursor_q;
    assign BUSY      = (state_q != S_IDLE);
    assign TX_WE     = tx_we_q;
    assign TX_DATA   = tx_data_q;
    assign RX_DROP   = rx_drop_q;
    assign KEY_DROP  = key_drop_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_terminal_char_arbiter.sv
// Directed self-checking bench for terminal_char_arbiter (small BLINK_DIV so blink events are quick).
module tb_terminal_char_arbiter;

    localparam int BLINK_DIV = 32;
    localparam int WR_GAP    = 2;
    localparam int KEY_DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       KEY_VALID = 1'b0;
    logic [7:0] KEY_CHAR = 8'h00;
    logic [7:0] SWITCHES = 8'h00;
    logic       RX_VALID = 1'b0;
    logic [7:0] RX_CHAR = 8'h00;
    logic       TX_READY = 1'b0;
    logic       TX_WE;
    logic [7:0] TX_DATA;
    logic       CHAR_WE;
    logic [7:0] CHAR;
    logic       CURSOR_ON;
    logic       BUSY;
    logic       RX_DROP;
    logic       KEY_DROP;
    logic [2:0] DBG_STATE;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] wr_log[$];
    int         wr_cyc[$];
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         rx_drops = 0;
    int         key_drops = 0;
    logic       prev_we = 1'b0;

    terminal_char_arbiter #(
        .BLINK_DIV(BLINK_DIV),
        .WR_GAP   (WR_GAP),
        .KEY_DEPTH(KEY_DEPTH)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .KEY_VALID(KEY_VALID),
        .KEY_CHAR (KEY_CHAR),
        .SWITCHES (SWITCHES),
        .RX_VALID (RX_VALID),
        .RX_CHAR  (RX_CHAR),
        .TX_READY (TX_READY),
        .TX_WE    (TX_WE),
        .TX_DATA  (TX_DATA),
        .CHAR_WE  (CHAR_WE),
        .CHAR     (CHAR),
        .CURSOR_ON(CURSOR_ON),
        .BUSY     (BUSY),
        .RX_DROP  (RX_DROP),
        .KEY_DROP (KEY_DROP),
        .DBG_STATE(DBG_STATE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (CHAR_WE) begin
            checks++;
            if (prev_we) begin
                failures++;
                $display("FAIL char_we_back_to_back at cyc %0d: got two consecutive strobes, need a gap", cyc);
            end
            wr_log.push_back(CHAR);
            wr_cyc.push_back(cyc);
        end
        prev_we = CHAR_WE;
        if (TX_WE) begin
            tx_log.push_back(TX_DATA);
            tx_cyc.push_back(cyc);
        end
        if (RX_DROP) rx_drops++;
        if (KEY_DROP) key_drops++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        tx_log.delete();
        tx_cyc.delete();
        rx_drops = 0;
        key_drops = 0;
        prev_we = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET_N   = 1'b0;
        KEY_VALID = 1'b0;
        RX_VALID  = 1'b0;
        TX_READY  = 1'b0;
        tick(2);
        RESET_N = 1'b1;
        clear_logs();
    endtask

    task automatic pulse_rx(input logic [7:0] c, output int n);
        @(negedge CLK);
        RX_VALID = 1'b1;
        RX_CHAR  = c;
        n = cyc;
        @(negedge CLK);
        RX_VALID = 1'b0;
    endtask

    task automatic wait_cursor_on();
        int k;
        k = 0;
        while (!CURSOR_ON && k < 4 * BLINK_DIV) begin
            @(negedge CLK);
            k++;
        end
        checks++;
        if (!CURSOR_ON) begin
            failures++;
            $display("FAIL cursor_wait: CURSOR_ON still %0b after %0d cycles, need 1", CURSOR_ON, k);
        end
        tick(4);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({CHAR_WE, CHAR, CURSOR_ON, BUSY} !== 11'd0) begin
            failures++;
            $display("FAIL reset_char_path: got we=%0b char=%h cur=%0b busy=%0b, need all 0", CHAR_WE, CHAR, CURSOR_ON, BUSY);
        end
        checks++;
        if ({TX_WE, TX_DATA, RX_DROP, KEY_DROP} !== 11'd0) begin
            failures++;
            $display("FAIL reset_tx_path: got tx_we=%0b tx_data=%h rxd=%0b keyd=%0b, need all 0", TX_WE, TX_DATA, RX_DROP, KEY_DROP);
        end
        tick(2);
        RESET_N = 1'b1;
    endtask

    task automatic test_blink();
        SWITCHES = 8'h41;
        apply_reset();
        tick(45);
        checks++;
        if (CURSOR_ON !== 1'b1) begin
            failures++;
            $display("FAIL blink_on_cursor: CURSOR_ON=%0b, need 1", CURSOR_ON);
        end
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== 8'h41) begin
            failures++;
            $display("FAIL blink_on_write: %0d writes, first=%h, need 1 write of 41", wr_log.size(), wr_log[0]);
        end
        tick(35);
        checks++;
        if (CURSOR_ON !== 1'b0) begin
            failures++;
            $display("FAIL blink_off_cursor: CURSOR_ON=%0b, need 0", CURSOR_ON);
        end
        checks++;
        if (wr_log.size() != 2 || wr_log[1] !== 8'h08) begin
            failures++;
            $display("FAIL blink_off_write: %0d writes, second=%h, need 41 then 08", wr_log.size(), wr_log[1]);
        end
    endtask

    task automatic test_rx_latency();
        int n;
        apply_reset();
        pulse_rx(8'h37, n);
        tick(8);
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== 8'h37) begin
            failures++;
            $display("FAIL rx_plain_write: %0d writes, first=%h, need one write of 37", wr_log.size(), wr_log[0]);
        end
        checks++;
        if (wr_cyc.size() != 1 || wr_cyc[0] - n != 2) begin
            failures++;
            $display("FAIL rx_latency: strobe %0d cycles after RX_VALID, need 2", wr_cyc[0] - n);
        end
        checks++;
        if (BUSY !== 1'b0 || tx_log.size() != 0) begin
            failures++;
            $display("FAIL rx_plain_idle: busy=%0b tx_count=%0d, need busy 0 and no TX", BUSY, tx_log.size());
        end
    endtask

    task automatic test_erase_rx();
        int n;
        SWITCHES = 8'h41;
        apply_reset();
        wait_cursor_on();
        clear_logs();
        pulse_rx(8'h5A, n);
        tick(12);
        checks++;
        if (wr_log.size() != 2 || wr_log[0] !== 8'h08 || wr_log[1] !== 8'h5A) begin
            failures++;
            $display("FAIL erase_seq: %0d writes (%h,%h), need 08 then 5A", wr_log.size(), wr_log[0], wr_log[1]);
        end
        checks++;
        if (wr_cyc.size() != 2 || wr_cyc[0] - n != 2 || wr_cyc[1] - wr_cyc[0] != WR_GAP + 1) begin
            failures++;
            $display("FAIL erase_timing: erase at +%0d, write %0d after, need +2 and %0d", wr_cyc[0] - n, wr_cyc[1] - wr_cyc[0], WR_GAP + 1);
        end
        checks++;
        if (CURSOR_ON !== 1'b0 || tx_log.size() != 0) begin
            failures++;
            $display("FAIL erase_after: cur=%0b tx_count=%0d, need cursor 0 and no TX", CURSOR_ON, tx_log.size());
        end
    endtask

    task automatic test_key_fifo();
        logic [7:0] exp_q[$];
        logic ok;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            KEY_VALID = 1'b1;
            KEY_CHAR  = 8'h31 + 8'(i);
        end
        @(negedge CLK);
        KEY_VALID = 1'b0;
        tick(3);
        checks++;
        if (key_drops != 1 || tx_log.size() != 0) begin
            failures++;
            $display("FAIL key_full_drop: drops=%0d tx_count=%0d, need 1 drop and no TX", key_drops, tx_log.size());
        end
        TX_READY = 1'b1;
        tick(14);
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34};
        ok = (tx_log.size() == exp_q.size());
        for (int i = 0; i < exp_q.size() && ok; i++) ok = (tx_log[i] === exp_q[i]);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL key_tx_order: %0d TX loads first=%h last=%h, need 31..34", tx_log.size(), tx_log[0], tx_log[tx_log.size()-1]);
        end
        ok = (tx_cyc.size() == 4);
        for (int i = 1; i < tx_cyc.size() && ok; i++) ok = (tx_cyc[i] - tx_cyc[i-1] >= 2);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL key_tx_gap: %0d TX loads, need 4 separated by at least one idle cycle", tx_cyc.size());
        end
        ok = 1'b1;
`ifdef LOCAL_ECHO_EN
        ok = (wr_log.size() == exp_q.size());
        for (int i = 0; i < exp_q.size() && ok; i++) ok = (wr_log[i] === exp_q[i]);
`else
        ok = (wr_log.size() == 0);
`endif
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL key_display: %0d display writes, first=%h, wrong for echo mode", wr_log.size(), wr_log[0]);
        end
    endtask

    task automatic test_simultaneous();
        logic ok;
        apply_reset();
        TX_READY = 1'b1;
        @(negedge CLK);
        RX_VALID  = 1'b1;
        RX_CHAR   = 8'h52;
        KEY_VALID = 1'b1;
        KEY_CHAR  = 8'h4B;
        @(negedge CLK);
        RX_VALID  = 1'b0;
        KEY_VALID = 1'b0;
        tick(14);
`ifdef LOCAL_ECHO_EN
        ok = (wr_log.size() == 2) && (wr_log[0] === 8'h52) && (wr_log[1] === 8'h4B);
`else
        ok = (wr_log.size() == 1) && (wr_log[0] === 8'h52);
`endif
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL simul_display: %0d writes first=%h, need 52 first (then 4B with echo)", wr_log.size(), wr_log[0]);
        end
        checks++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'h4B) begin
            failures++;
            $display("FAIL simul_tx: %0d TX loads first=%h, need one load of 4B", tx_log.size(), tx_log[0]);
        end
    endtask

    task automatic test_rx_drop();
        int n;
        apply_reset();
        pulse_rx(8'h61, n);
        @(negedge CLK);
        RX_VALID = 1'b1;
        RX_CHAR  = 8'h62;
        checks++;
        if (BUSY !== 1'b1) begin
            failures++;
            $display("FAIL rx_drop_busy: BUSY=%0b during second RX, need 1", BUSY);
        end
        @(negedge CLK);
        RX_VALID = 1'b0;
        tick(8);
        checks++;
        if (rx_drops != 1) begin
            failures++;
            $display("FAIL rx_drop_pulse: %0d RX_DROP pulses, need 1", rx_drops);
        end
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== 8'h61) begin
            failures++;
            $display("FAIL rx_drop_write: %0d writes first=%h, need only 61", wr_log.size(), wr_log[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        SWITCHES = 8'h41;
        apply_reset();
        wait_cursor_on();
        clear_logs();
        pulse_rx(8'h5A, n);
        tick(2);
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== 8'h08 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL mid_erase_done: %0d writes first=%h busy=%0b, need one 08 and busy", wr_log.size(), wr_log[0], BUSY);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({CHAR_WE, CHAR, CURSOR_ON, BUSY, TX_WE, TX_DATA, RX_DROP, KEY_DROP} !== 20'd0) begin
            failures++;
            $display("FAIL mid_async_reset: char=%h busy=%0b cur=%0b tx=%h, need all outputs 0", CHAR, BUSY, CURSOR_ON, TX_DATA);
        end
        tick(2);
        RESET_N = 1'b1;
        clear_logs();
        tick(20);
        checks++;
        if (wr_log.size() != 0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_write: %0d writes after release busy=%0b, need none", wr_log.size(), BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_rx_latency();
        test_erase_rx();
        test_key_fifo();
        test_simultaneous();
        test_rx_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
